// File: rtl/xbox_xlr_matmul_pkg.sv
// xbox_xlr_matmul_pkg: shared types and constants for the XBOX matrix-multiply accelerator
package xbox_xlr_matmul_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_B, S_RD_A, S_CAP, S_MAC, S_WR, S_DONE} state_e;
    typedef enum logic [4:0] {REG_START, REG_BUSY, REG_STATUS, REG_CFG, REG_BASE, REG_CYCLES} reg_e;
    typedef enum logic {MEM0, MEM1} mem_e;
    localparam int DIM_LO = 2;
    localparam int DIM_HI = 8;
    localparam int LANES = 8;
    localparam logic [31:0] RD_MASK = 32'h0000_0026;
endpackage

// File: rtl/xbox_xlr_mac_row.sv
// xbox_xlr_mac_row: one row of 32-bit multiply-accumulate lanes with clear and per-lane enable
module xbox_xlr_mac_row
    import xbox_xlr_matmul_pkg::*;
#(
    parameter int LANES_P = LANES
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic [LANES_P-1:0]         en_i,
    input  logic [31:0]                a_i,
    input  logic [LANES_P-1:0][31:0]   b_i,
    output logic [LANES_P-1:0][31:0]   acc_o
);
    logic [LANES_P-1:0][31:0] acc_q, acc_d;

    always_comb begin
        for (int j = 0; j < LANES_P; j++)
            acc_d[j] = clr_i ? '0 : en_i[j] ? acc_q[j] + a_i * b_i[j] : acc_q[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/xbox_xlr_matmul.sv
// xbox_xlr_matmul: host-started n x n unsigned matmul, A from MEM0, B read from and C written to MEM1
module xbox_xlr_matmul
    import xbox_xlr_matmul_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int DIM_MAX            = 8
)(
    input  logic                                          clk,
    input  logic                                          rst,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
    output logic [NUM_MEMS-1:0][7:0][31:0]                xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                     xlr_mem_be,
    output logic [NUM_MEMS-1:0]                           xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                           xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]                xlr_mem_rdata,
    input  logic [31:0][31:0]                             host_regs,
    input  logic [31:0]                                   host_regs_valid_pulse,
    output logic [31:0][31:0]                             host_regs_data_out,
    output logic [31:0]                                   host_regs_valid_out
);
    localparam int AW = LOG2_LINES_PER_MEM;

    state_e                  state_q, state_d;
    logic                    start_q, start_in, accept, bad_n, busy, last_k, k_inc, rd_b, wr_c;
    logic [3:0]              n_q, k_q, i_q;
    logic [AW-1:0]           a_base_q, b_base_q, c_base_q;
    logic [7:0][31:0]        arow_q, acc;
    logic [7:0][7:0][31:0]   bbuf_q;
    logic [31:0]             cyc_q;
    logic                    done_q, err_q;
    logic [7:0]              lane_en;
    logic [31:0][31:0]       dout_d;
    logic                    unused_in;

    // a start is only taken while idle and not already pending, so CFG/BASE cannot be clobbered mid-run
    assign start_in = host_regs_valid_pulse[REG_START] && host_regs[REG_START] == 32'd1
                      && state_q == S_IDLE && !start_q;
    assign accept   = start_q && state_q == S_IDLE;
    assign bad_n    = n_q < 4'(DIM_LO) || n_q > 4'(DIM_MAX);
    assign busy     = state_q inside {S_LOAD_B, S_RD_A, S_CAP, S_MAC, S_WR};
    assign last_k   = k_q == n_q - 4'd1;
    assign k_inc    = (state_q == S_LOAD_B && k_q != n_q) || (state_q == S_MAC && !last_k);
    assign rd_b     = state_q == S_LOAD_B && k_q != n_q;
    assign wr_c     = state_q == S_WR;
    assign unused_in = ^{host_regs, host_regs_valid_pulse, xlr_mem_rdata};

    always_comb begin
        for (int j = 0; j < 8; j++) lane_en[j] = 4'(j) < n_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = bad_n ? S_DONE : S_LOAD_B;
            S_LOAD_B: if (k_q == n_q) state_d = S_RD_A;
            S_RD_A:   state_d = S_CAP;
            S_CAP:    state_d = S_MAC;
            S_MAC:    if (last_k) state_d = S_WR;
            S_WR:     state_d = i_q == n_q - 4'd1 ? S_DONE : S_RD_A;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        xlr_mem_addr  = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be    = '0;
        xlr_mem_rd    = '0;
        xlr_mem_wr    = '0;
        xlr_mem_rd[MEM0]   = state_q == S_RD_A;
        xlr_mem_addr[MEM0] = state_q == S_RD_A ? a_base_q + AW'(i_q) : '0;
        xlr_mem_rd[MEM1]   = rd_b;
        xlr_mem_wr[MEM1]   = wr_c;
        xlr_mem_addr[MEM1] = rd_b ? b_base_q + AW'(k_q) : wr_c ? c_base_q + AW'(i_q) : '0;
        xlr_mem_be[MEM1]   = wr_c ? 32'hFFFF_FFFF >> (6'd32 - {n_q, 2'b00}) : '0;
        for (int j = 0; j < 8; j++) xlr_mem_wdata[MEM1][j] = wr_c && lane_en[j] ? acc[j] : '0;
    end

    always_comb begin
        dout_d = '0;
        dout_d[REG_BUSY][0]      = busy;
        dout_d[REG_STATUS][1:0]  = {err_q, done_q};
        dout_d[REG_CYCLES]       = cyc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q             <= 1'b0;
            n_q                 <= '0;
            a_base_q            <= '0;
            b_base_q            <= '0;
            c_base_q            <= '0;
            k_q                 <= '0;
            i_q                 <= '0;
            arow_q              <= '0;
            bbuf_q              <= '0;
            cyc_q               <= '0;
            done_q              <= 1'b0;
            err_q               <= 1'b0;
            host_regs_data_out  <= '0;
            host_regs_valid_out <= '0;
        end else begin
            start_q <= start_in;
            if (start_in) begin
                n_q      <= host_regs[REG_CFG][3:0];
                a_base_q <= AW'(host_regs[REG_BASE][7:0]);
                b_base_q <= AW'(host_regs[REG_BASE][15:8]);
                c_base_q <= AW'(host_regs[REG_BASE][23:16]);
            end
            k_q <= k_inc ? k_q + 4'd1 : '0;
            i_q <= accept ? '0 : wr_c ? i_q + 4'd1 : i_q;
            // B row k arrives one cycle after its read, hence the k-1 slot
            if (state_q == S_LOAD_B && k_q != '0) bbuf_q[3'(k_q - 4'd1)] <= xlr_mem_rdata[MEM1];
            if (state_q == S_CAP) arow_q <= xlr_mem_rdata[MEM0];
            cyc_q               <= accept ? '0 : busy ? cyc_q + 32'd1 : cyc_q;
            done_q              <= !accept && (done_q || state_q == S_DONE);
            err_q               <= accept ? bad_n : err_q;
            host_regs_data_out  <= dout_d;
            host_regs_valid_out <= RD_MASK;
        end
    end

    xbox_xlr_mac_row #(.LANES_P(8)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == S_CAP),
        .en_i  (lane_en & {8{state_q == S_MAC}}),
        .a_i   (arow_q[k_q[2:0]]),
        .b_i   (bbuf_q[k_q[2:0]]),
        .acc_o (acc)
    );
endmodule

// File: tb/tb_xbox_xlr_matmul.sv
// tb_xbox_xlr_matmul: table-driven and randomized check of xbox_xlr_matmul against a plain matmul model
module tb_xbox_xlr_matmul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][7:0]        addr;
    logic [1:0][7:0][31:0]  wdata, rdata;
    logic [1:0][31:0]       be;
    logic [1:0]             rd, wr;
    logic [31:0][31:0]      hregs, dout;
    logic [31:0]            hpulse, vout;

    xbox_xlr_matmul #(.NUM_MEMS(2), .LOG2_LINES_PER_MEM(8), .DIM_MAX(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .xlr_mem_addr          (addr),
        .xlr_mem_wdata         (wdata),
        .xlr_mem_be            (be),
        .xlr_mem_rd            (rd),
        .xlr_mem_wr            (wr),
        .xlr_mem_rdata         (rdata),
        .host_regs             (hregs),
        .host_regs_valid_pulse (hpulse),
        .host_regs_data_out    (dout),
        .host_regs_valid_out   (vout)
    );

    typedef struct { logic [7:0] a; logic [255:0] d; logic [31:0] be; } wr_t;
    typedef struct { int n; logic [7:0] ab; logic [7:0] bb; logic [7:0] cb; int kind; int cyc; logic err; } vec_t;

    logic [255:0] m0 [256];
    logic [255:0] m1 [256];
    wr_t          wlog[$];
    int           rd_cnt = 0, wr_cnt = 0, busy_cnt = 0;
    int           compared = 0, mismatched = 0;
    logic [255:0] wv;

    // synchronous memory model: read data appears the cycle after rd, writes honour byte enables
    always @(posedge clk) begin
        if (rd[0]) begin rd_cnt++; rdata[0] <= m0[addr[0]]; end
        if (rd[1]) begin rd_cnt++; rdata[1] <= m1[addr[1]]; end
        if (wr[0]) wr_cnt++;
        if (wr[1]) begin
            wr_cnt++;
            wv = wdata[1];
            wlog.push_back('{addr[1], wv, be[1]});
            for (int b = 0; b < 32; b++) if (be[1][b]) m1[addr[1]][8*b +: 8] = wv[8*b +: 8];
        end
    end

    always @(negedge clk) if (dout[1][0]) busy_cnt++;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    task automatic prep(input int kind, input int n, input logic [7:0] ab, input logic [7:0] bb);
        for (int i = 0; i < 8; i++) begin
            m0[8'(ab + i)] = rnd_line();
            m1[8'(bb + i)] = rnd_line();
            for (int k = 0; k < n && k < 8; k++) begin
                if (kind == 1) m0[8'(ab + i)][32*k +: 32] = (k == i) ? 32'd1 : 32'd0;
                if (kind == 3) begin
                    m0[8'(ab + i)][32*k +: 32] = '0;
                    m1[8'(bb + i)][32*k +: 32] = '0;
                end
            end
        end
        if (kind == 2) begin
            m0[ab][31:0] = 1;                 m0[ab][63:32] = 2;
            m0[8'(ab + 1)][31:0] = 3;         m0[8'(ab + 1)][63:32] = 4;
            m1[bb][31:0] = 5;                 m1[bb][63:32] = 6;
            m1[8'(bb + 1)][31:0] = 7;         m1[8'(bb + 1)][63:32] = 8;
        end
        if (kind == 3) begin
            m0[ab][31:0] = 32'hFFFF_FFFF;
            m1[bb][31:0] = 32'd2;
        end
    endtask

    task automatic run(input int n, input logic [7:0] ab, input logic [7:0] bb, input logic [7:0] cb,
                       input int exp_cyc, input logic exp_err, input int inj, input string tag, output int q0);
        logic [255:0] cexp [8];
        logic [31:0]  s;
        logic [31:0]  mask;
        int           r0, w0, b0;
        logic         ok;
        for (int i = 0; i < 8; i++) begin
            cexp[i] = '0;
            for (int j = 0; j < n && i < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += m0[8'(ab + i)][32*k +: 32] * m1[8'(bb + k)][32*j +: 32];
                cexp[i][32*j +: 32] = s;
            end
        end
        mask = n >= 8 ? 32'hFFFF_FFFF : 32'((64'd1 << (4 * n)) - 64'd1);
        @(negedge clk);
        q0 = wlog.size(); r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cnt;
        hregs[3] = 32'(n); hregs[4] = {8'h00, cb, bb, ab}; hregs[0] = 32'd1; hpulse[0] = 1'b1;
        ok = 1'b0;
        for (int c = 1; c <= 400 && !ok; c++) begin
            @(negedge clk);
            hpulse[0] = (c == inj);
            if (c == inj) begin hregs[3] = 32'd8; hregs[4] = 32'h0077_6655; end
            if (c >= 3 && dout[2][0]) ok = 1'b1;
        end
        chk({tag, "_finish_in_time"}, ok, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, dout[2][0], 1);
        chk({tag, "_err"}, dout[2][1], exp_err);
        chk({tag, "_cycles"}, dout[5], exp_cyc);
        chk({tag, "_busy_cycles"}, busy_cnt - b0, exp_cyc);
        chk({tag, "_reads"}, rd_cnt - r0, exp_err ? 0 : 2 * n);
        chk({tag, "_writes"}, wr_cnt - w0, exp_err ? 0 : n);
        for (int i = 0; i < n && !exp_err; i++) begin
            if (wlog.size() > q0 + i) begin
                chk($sformatf("%s_row%0d_addr", tag, i), wlog[q0 + i].a, 8'(cb + i));
                chk($sformatf("%s_row%0d_data", tag, i), wlog[q0 + i].d, cexp[i]);
                chk($sformatf("%s_row%0d_be", tag, i), wlog[q0 + i].be, mask);
            end
        end
    endtask

    vec_t         tbl[11];
    int           q0, w0;
    logic         seen;
    logic [255:0] pre, r0e, r1e;

    initial begin
        hregs = '0; hpulse = '0;
        for (int l = 0; l < 256; l++) begin m0[l] = rnd_line(); m1[l] = rnd_line(); end
        tbl[0]  = '{2,  8'h10, 8'h20, 8'h30, 2, 13, 1'b0};
        tbl[1]  = '{8,  8'h40, 8'h50, 8'h60, 1, 97, 1'b0};
        tbl[2]  = '{2,  8'h70, 8'h78, 8'h80, 3, 13, 1'b0};
        tbl[3]  = '{1,  8'hE0, 8'hE8, 8'hF0, 0, 0,  1'b1};
        tbl[4]  = '{9,  8'hE0, 8'hE8, 8'hF0, 0, 0,  1'b1};
        tbl[5]  = '{2,  8'h90, 8'h98, 8'hFF, 0, 13, 1'b0};
        tbl[6]  = '{4,  8'hA0, 8'hFE, 8'hB0, 0, 33, 1'b0};
        tbl[7]  = '{8,  8'hC0, 8'hC8, 8'hD0, 0, 97, 1'b0};
        tbl[8]  = '{0,  8'hE0, 8'hE8, 8'hF0, 0, 0,  1'b1};
        tbl[9]  = '{15, 8'hE0, 8'hE8, 8'hF0, 0, 0,  1'b1};
        tbl[10] = '{3,  8'h18, 8'h28, 8'h38, 0, 22, 1'b0};
        r0e = '0; r0e[31:0] = 32'd19; r0e[63:32] = 32'd22;
        r1e = '0; r1e[31:0] = 32'd43; r1e[63:32] = 32'd50;

        repeat (3) @(negedge clk);
        chk("reset_rd", rd, 0);
        chk("reset_wr", wr, 0);
        chk("reset_be", be, 0);
        chk("reset_addr", addr, 0);
        chk("reset_wdata", |wdata, 0);
        chk("reset_dout", |dout, 0);
        chk("reset_vout", vout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("valid_out", vout, 32'h26);
        chk("idle_busy", dout[1], 0);

        foreach (tbl[v]) begin
            prep(tbl[v].kind, tbl[v].n, tbl[v].ab, tbl[v].bb);
            run(tbl[v].n, tbl[v].ab, tbl[v].bb, tbl[v].cb, tbl[v].cyc, tbl[v].err, 0, $sformatf("vec%0d", v), q0);
            if (tbl[v].kind == 2 && wlog.size() >= q0 + 2) begin
                chk("mm2_c_row0", wlog[q0].d, r0e);
                chk("mm2_c_row1", wlog[q0 + 1].d, r1e);
            end
            if (tbl[v].kind == 3 && wlog.size() > q0) chk("overflow_c00", wlog[q0].d[31:0], 32'hFFFF_FFFE);
        end

        for (int r = 0; r < 6; r++) begin
            int n;
            logic [7:0] ab;
            n  = $urandom_range(2, 8);
            ab = 8'($urandom);
            prep(0, n, ab, 8'(ab + 16));
            run(n, ab, 8'(ab + 16), 8'(ab + 32), (n + 1) + n * (n + 3), 1'b0, 0, $sformatf("rnd%0d", r), q0);
        end

        prep(2, 2, 8'h10, 8'h20);
        run(2, 8'h10, 8'h20, 8'h30, 13, 1'b0, 7, "midstart", q0);
        if (wlog.size() >= q0 + 2) begin
            chk("midstart_c_row0", wlog[q0].d, r0e);
            chk("midstart_c_row1", wlog[q0 + 1].d, r1e);
        end

        prep(2, 2, 8'h10, 8'h20);
        m1[8'h44] = rnd_line();
        pre = m1[8'h44];
        @(negedge clk);
        w0 = wr_cnt;
        hregs[3] = 32'd2; hregs[4] = {8'h00, 8'h44, 8'h20, 8'h10}; hregs[0] = 32'd1; hpulse[0] = 1'b1;
        @(negedge clk);
        hpulse[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (wr[1]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rstwr_reached_wr", seen, 1);
        rst = 1'b1;
        #1;
        chk("rstwr_wr", wr, 0);
        chk("rstwr_rd", rd, 0);
        chk("rstwr_be", be, 0);
        chk("rstwr_dout", |dout, 0);
        chk("rstwr_vout", vout, 0);
        repeat (2) @(negedge clk);
        chk("rstwr_line_kept", m1[8'h44], pre);
        chk("rstwr_no_write", wr_cnt - w0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(2, 8'h10, 8'h20, 8'h30, 13, 1'b0, 0, "after_rst", q0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
